// File: rtl/mem_access_unit.sv
// Load/store unit between the core datapath and an Avalon-MM master port.
// It runs one request at a time, holds the bus transaction across waitrequest and returns the extended load data.
module mem_access_unit #(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic        wen_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic [31:0] address_o,
  output logic        read_o,
  output logic        write_o,
  input  logic        waitrequest_i,
  output logic [31:0] writedata_o,
  output logic [3:0]  byteenable_o,
  input  logic [31:0] readdata_i,
  output logic [1:0]  state_o
);

  // Avalon handshake: read_o/write_o and every address/data/enable output stay
  // constant while waitrequest_i=1. The transfer completes on the first rising
  // edge where a strobe is high and waitrequest_i=0.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        wen_q, wen_d;
  logic        sign_q, sign_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  lane_q, lane_d;
  logic        busy_d, done_d, err_d, read_d, write_d;
  logic [31:0] rdata_d, address_d, writedata_d;
  logic [3:0]  be_d;

  function automatic logic legal(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   legal = 1'b1;
      2'b01:   legal = ~a[0];
      2'b10:   legal = (a == 2'b00);
      default: legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] be_of(input logic [1:0] sz, input logic [1:0] a);
    logic [3:0] le;
    case (sz)
      2'b00:   le = 4'b0001 << a;
      2'b01:   le = a[1] ? 4'b1100 : 4'b0011;
      default: le = 4'b1111;
    endcase
    if (BIG_ENDIAN) be_of = {le[0], le[1], le[2], le[3]};
    else            be_of = le;
  endfunction

  // The lane index is physical: in big-endian mode, byte n sits in lane 3-n.
  function automatic logic [31:0] extract(input logic [31:0] d, input logic [1:0] sz,
                                          input logic sg, input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = lane[1] ? d[31:16] : d[15:0];
    case (sz)
      2'b00:   extract = {{24{sg & b[7]}}, b};
      2'b01:   extract = {{16{sg & h[15]}}, h};
      default: extract = d;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    wen_d       = wen_q;
    sign_d      = sign_q;
    size_d      = size_q;
    lane_d      = lane_q;
    busy_d      = busy_o;
    done_d      = 1'b0;
    err_d       = err_o;
    rdata_d     = rdata_o;
    address_d   = address_o;
    read_d      = read_o;
    write_d     = write_o;
    writedata_d = writedata_o;
    be_d        = byteenable_o;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          wen_d  = wen_i;
          sign_d = sign_i;
          size_d = size_i;
          lane_d = BIG_ENDIAN ? ~addr_i[1:0] : addr_i[1:0];
          if (legal(size_i, addr_i[1:0])) begin
            state_d     = ACCESS;
            busy_d      = 1'b1;
            err_d       = 1'b0;
            read_d      = ~wen_i;
            write_d     = wen_i;
            address_d   = {addr_i[31:2], 2'b00};
            be_d        = be_of(size_i, addr_i[1:0]);
            case (size_i)
              2'b00:   writedata_d = {4{wdata_i[7:0]}};
              2'b01:   writedata_d = {2{wdata_i[15:0]}};
              default: writedata_d = wdata_i;
            endcase
          end else begin
            // Illegal requests complete without touching the bus.
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (!waitrequest_i) begin
          state_d = DONE;
          read_d  = 1'b0;
          write_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (!wen_q) rdata_d = extract(readdata_i, size_q, sign_q, lane_q);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= IDLE;
      wen_q        <= 1'b0;
      sign_q       <= 1'b0;
      size_q       <= 2'b00;
      lane_q       <= 2'b00;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      rdata_o      <= 32'h0;
      address_o    <= 32'h0;
      read_o       <= 1'b0;
      write_o      <= 1'b0;
      writedata_o  <= 32'h0;
      byteenable_o <= 4'b0000;
    end else begin
      state_q      <= state_d;
      wen_q        <= wen_d;
      sign_q       <= sign_d;
      size_q       <= size_d;
      lane_q       <= lane_d;
      busy_o       <= busy_d;
      done_o       <= done_d;
      err_o        <= err_d;
      rdata_o      <= rdata_d;
      address_o    <= address_d;
      read_o       <= read_d;
      write_o      <= write_d;
      writedata_o  <= writedata_d;
      byteenable_o <= be_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: driver tasks issue requests, and a monitor
// checks every done_o against an expected-response queue.
module tb_mem_access_unit;

  logic        clk;
  logic        reset_i;
  logic        req_i;
  logic        wen_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [1:0]  size_i;
  logic        sign_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] rdata_o;
  logic [31:0] address_o;
  logic        read_o;
  logic        write_o;
  logic        waitrequest_i;
  logic [31:0] writedata_o;
  logic [3:0]  byteenable_o;
  logic [31:0] readdata_i;
  logic [1:0]  state_o;

  int n_checks = 0;
  int n_pass   = 0;
  logic [32:0] exp_q[$];

  mem_access_unit #(.BIG_ENDIAN(1'b0)) dut (
    .clk(clk), .reset_i(reset_i), .req_i(req_i), .wen_i(wen_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .size_i(size_i), .sign_i(sign_i), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .waitrequest_i(waitrequest_i),
    .writedata_o(writedata_o), .byteenable_o(byteenable_o), .readdata_i(readdata_i),
    .state_o(state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h", name, act, exp);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin : monitor
    logic [32:0] e;
    if (reset_i && done_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(done_o), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("done_err_rdata", 64'({err_o, rdata_o}), 64'(e));
      end
    end
  end

  // Issue one request from IDLE (called at a negedge) and follow it to completion.
  task automatic do_req(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] sz, input logic sg, input int nwait,
                        input logic [31:0] rd, input logic exp_err, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd, input logic [31:0] exp_rdata, input bit poke);
    logic [31:0] exp_addr;
    exp_addr = {addr[31:2], 2'b00};
    req_i = 1'b1; wen_i = wen; addr_i = addr; wdata_i = wd; size_i = sz; sign_i = sg;
    waitrequest_i = (nwait > 0); readdata_i = rd;
    exp_q.push_back({exp_err, exp_rdata});
    @(posedge clk); #1 req_i = 1'b0;
    @(negedge clk);
    if (exp_err) begin
      check("err_done_latency", 64'(done_o), 64'(1));
      check("err_no_strobe", 64'({read_o, write_o, busy_o}), 64'(0));
    end else begin
      check("strobe", 64'({read_o, write_o, busy_o}), 64'({~wen, wen, 1'b1}));
      check("address", 64'(address_o), 64'(exp_addr));
      check("byteenable", 64'(byteenable_o), 64'(exp_be));
      if (wen) check("writedata", 64'(writedata_o), 64'(exp_wd));
      for (int i = 0; i < nwait; i++) begin
        if (poke && i == 0) begin
          req_i = 1'b1; wen_i = 1'b1; addr_i = 32'h0000_0500; size_i = 2'b10;
        end
        @(negedge clk);
        req_i = 1'b0;
        check("hold_during_wait", 64'({read_o, write_o, done_o, byteenable_o, address_o}),
              64'({~wen, wen, 1'b0, exp_be, exp_addr}));
      end
      waitrequest_i = 1'b0;
      @(negedge clk);
      check("complete", 64'({done_o, busy_o, read_o, write_o}), 64'(4'b1000));
    end
    @(negedge clk);
    check("back_to_idle", 64'({done_o, state_o, err_o}), 64'({1'b0, 2'd0, exp_err}));
  endtask

  initial begin : driver
    int dones;
    reset_i = 1'b0; req_i = 1'b0; wen_i = 1'b0; addr_i = '0; wdata_i = '0;
    size_i = 2'b00; sign_i = 1'b0; waitrequest_i = 1'b0; readdata_i = '0;
    repeat (2) @(negedge clk);
    check("reset_ctrl", 64'({busy_o, done_o, err_o, read_o, write_o, byteenable_o, state_o}), 64'(0));
    check("reset_data", 64'({rdata_o, address_o}), 64'(0));
    check("reset_wdata", 64'(writedata_o), 64'(0));
    reset_i = 1'b1;
    @(negedge clk);

    do_req(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 0, 32'hDEADBEEF, 1'b0, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b0);
    do_req(1'b0, 32'h103, 32'h0, 2'b00, 1'b1, 3, 32'h80FF0000, 1'b0, 4'b1000, 32'h0, 32'hFFFFFF80, 1'b0);
    do_req(1'b0, 32'h103, 32'h0, 2'b00, 1'b0, 3, 32'h80FF0000, 1'b0, 4'b1000, 32'h0, 32'h00000080, 1'b0);
    do_req(1'b1, 32'h202, 32'h1234ABCD, 2'b01, 1'b0, 2, 32'h0, 1'b0, 4'b1100, 32'hABCDABCD, 32'h00000080, 1'b0);
    do_req(1'b0, 32'h101, 32'h0, 2'b10, 1'b0, 0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h00000080, 1'b0);
    do_req(1'b0, 32'h100, 32'h0, 2'b11, 1'b0, 0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h00000080, 1'b0);
    do_req(1'b0, 32'h102, 32'h0, 2'b01, 1'b1, 1, 32'h80017FFF, 1'b0, 4'b1100, 32'h0, 32'hFFFF8001, 1'b0);
    do_req(1'b0, 32'h100, 32'h0, 2'b01, 1'b1, 0, 32'h80017FFF, 1'b0, 4'b0011, 32'h0, 32'h00007FFF, 1'b0);
    do_req(1'b1, 32'h101, 32'h000000A5, 2'b00, 1'b0, 0, 32'h0, 1'b0, 4'b0010, 32'hA5A5A5A5, 32'h00007FFF, 1'b0);
    do_req(1'b0, 32'h103, 32'h0, 2'b01, 1'b0, 0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h00007FFF, 1'b0);
    do_req(1'b0, 32'h101, 32'h0, 2'b00, 1'b1, 0, 32'h00007F00, 1'b0, 4'b0010, 32'h0, 32'h0000007F, 1'b0);
    do_req(1'b1, 32'h104, 32'hCAFEF00D, 2'b10, 1'b0, 1, 32'h0, 1'b0, 4'b1111, 32'hCAFEF00D, 32'h0000007F, 1'b0);
    do_req(1'b0, 32'h108, 32'h0, 2'b10, 1'b1, 3, 32'h80000000, 1'b0, 4'b1111, 32'h0, 32'h80000000, 1'b1);

    // Asynchronous reset in the middle of a stalled access.
    req_i = 1'b1; wen_i = 1'b0; addr_i = 32'h600; size_i = 2'b10; sign_i = 1'b0;
    waitrequest_i = 1'b1;
    @(posedge clk); #1 req_i = 1'b0;
    @(negedge clk);
    check("pre_reset_read", 64'({read_o, busy_o}), 64'(2'b11));
    #2 reset_i = 1'b0;
    #1;
    check("async_reset_ctrl", 64'({read_o, write_o, busy_o, byteenable_o, state_o}), 64'(0));
    check("async_reset_data", 64'({address_o, rdata_o}), 64'(0));
    @(negedge clk);
    reset_i = 1'b1; waitrequest_i = 1'b0;
    @(negedge clk);
    do_req(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 0, 32'h01234567, 1'b0, 4'b1111, 32'h0, 32'h01234567, 1'b0);

    // req_i held high: accepted only from IDLE, so two transactions in seven cycles.
    dones = 0;
    req_i = 1'b1; wen_i = 1'b0; addr_i = 32'h300; size_i = 2'b10; sign_i = 1'b0;
    waitrequest_i = 1'b0; readdata_i = 32'h11223344;
    exp_q.push_back({1'b0, 32'h11223344});
    exp_q.push_back({1'b0, 32'h11223344});
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      if (i == 4) req_i = 1'b0;
      @(negedge clk);
      if (done_o) dones++;
    end
    check("held_req_done_count", 64'(dones), 64'(2));
    check("held_req_idle", 64'({state_o, busy_o}), 64'(0));

    @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits between the CPU core datapath and the Avalon memory-mapped bus.
- Accepts one load/store request at a time from the core: byte, halfword or word, with signed or unsigned loads.
- Drives a single Avalon master transaction, holding it stable across waitrequest.
- Returns load data lane-extracted and extended, plus a one-cycle completion pulse that the core FSM uses to release its stall.

Parameters:
BIG_ENDIAN, 0, 0 = little-endian lane mapping (byte n at addr[1:0]=n occupies bits 8n+7:8n); 1 = byte n occupies bits 8(3-n)+7:8(3-n)

Ports:
clk  input  1  system clock, rising edge
reset_i  input  1  asynchronous, active-low reset
req_i  input  1  request valid; sampled only in IDLE
wen_i  input  1  1 = store, 0 = load
addr_i  input  32  byte address
wdata_i  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
size_i  input  2  00 byte, 01 halfword, 10 word, 11 reserved
sign_i  input  1  1 = sign-extend load result, 0 = zero-extend
busy_o  output  1  high from request acceptance until done_o
done_o  output  1  one-cycle completion pulse
err_o  output  1  valid with done_o; 1 = misaligned or reserved size, no bus access made
rdata_o  output  32  extended load result; valid from done_o, held until next done_o
address_o  output  32  Avalon address, word-aligned ({addr[31:2],2'b00})
read_o  output  1  Avalon read
write_o  output  1  Avalon write
waitrequest_i  input  1  Avalon waitrequest
writedata_o  output  32  Avalon write data
byteenable_o  output  4  Avalon byte enables
readdata_i  input  32  Avalon read data; valid when read_o & !waitrequest_i

Behaviour:
- Reset (reset_i low, asynchronous): state IDLE. busy_o, done_o, err_o, read_o and write_o all 0. rdata_o, address_o, writedata_o = 0. byteenable_o = 4'b0000. Deasserts mid-transaction immediately; any in-flight bus access is abandoned.
- FSM states: IDLE, ACCESS, DONE. All outputs are registered.
- IDLE with req_i=1:
  - Capture wen_i, addr_i, size_i, sign_i and wdata_i.
  - If aligned with a legal size: go to ACCESS next edge, with read_o=!wen, write_o=wen, busy_o=1.
  - Otherwise: go straight to DONE with err_o=1; no bus strobe asserted.
- Alignment rules:
  - Halfword requires addr[0]=0.
  - Word requires addr[1:0]=00.
  - size 11 is always an error.
- ACCESS:
  - address_o, byteenable_o, writedata_o, read_o and write_o are held constant while waitrequest_i=1. There is no limit on wait cycles.
  - On the edge where waitrequest_i=0: drop read_o/write_o, go to DONE. For loads, latch the extracted readdata_i into rdata_o on that same edge.
- DONE: done_o=1 for exactly one cycle, busy_o=0, then IDLE. req_i in DONE is ignored; a new request is accepted no earlier than the following IDLE cycle.
- Latency: req_i sampled at edge 0, strobe high after edge 0. With zero waits, done_o is high after edge 1. Each wait cycle adds 1.
- byteenable (little-endian):
  - Byte: 1<<addr[1:0].
  - Half: addr[1]=0 gives 0011, addr[1]=1 gives 1100.
  - Word: 1111.
  - BIG_ENDIAN mirrors the lanes.
- writedata_o:
  - Byte: {4{wdata[7:0]}}.
  - Half: {2{wdata[15:0]}}.
  - Word: wdata.
- Load extraction: select the enabled lane(s), right-align, then sign-extend if sign_i=1, else zero-extend. Word loads ignore sign_i.
- Error completion: rdata_o keeps its previous value. err_o is cleared on the next accepted request.
- req_i while busy_o=1 is ignored and does not queue.

Test Plan:
- Word load, addr 0x100, waitrequest 0, readdata 0xDEADBEEF -> read_o=1 for 1 cycle, address_o=0x100, byteenable_o=1111, done_o 2 cycles after req, rdata_o=0xDEADBEEF, err_o=0.
- Signed byte load, addr 0x103, readdata 0x80FF0000, 3 wait cycles -> byteenable_o=1000 held all 4 cycles, rdata_o=0xFFFFFF80; repeating with sign_i=0 gives 0x00000080.
- Halfword store, addr 0x202, wdata 0x1234ABCD -> write_o=1, address_o=0x200, byteenable_o=1100, writedata_o=0xABCDABCD, done_o after waitrequest drops.
- Misaligned word load at 0x101 and size_i=11 -> no read_o/write_o, done_o 1 cycle after req with err_o=1, rdata_o unchanged.
- reset_i pulled low during ACCESS with waitrequest 1 -> read_o, busy_o and byteenable_o drop to 0 before the next clock. After release, a new word load completes normally.
- req_i held high continuously -> requests accepted only from IDLE, so one done_o per transaction. A second req_i pulse during ACCESS is not executed.
